// File: rtl/pixel_pkg.sv
// Shared types and constants for the 2x2 pixel block frame sequencer.
package pixel_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ERASE   = 3'd1,
    EXPOSE  = 3'd2,
    CONVERT = 3'd3,
    READ12  = 3'd4,
    READ34  = 3'd5
  } state_e;

  localparam int C_ERASE_DEF   = 5;
  localparam int C_CONVERT_DEF = 255;
  localparam int PIX_W         = 8;

endpackage

// File: rtl/pixel_read_capture.sv
// Read-phase capture: one settle cycle, then a held 16-bit pixel pair offered
// downstream until accepted.
module pixel_read_capture
  import pixel_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               rd_active_i,
  input  logic               sel_hi_i,
  input  logic               clear_i,
  input  logic [PIX_W-1:0]   pix1_i,
  input  logic [PIX_W-1:0]   pix2_i,
  input  logic [PIX_W-1:0]   pix3_i,
  input  logic [PIX_W-1:0]   pix4_i,
  input  logic               ready_i,
  output logic [2*PIX_W-1:0] data_o,
  output logic               valid_o,
  output logic               accept_o
);

  logic [2*PIX_W-1:0] data_q, data_d;
  logic               valid_q, valid_d;

  // clear (abort) beats a simultaneous ready, so no accept is reported then
  assign accept_o = valid_q & ready_i & ~clear_i;

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (clear_i) begin
      data_d  = '0;
      valid_d = 1'b0;
    end else if (accept_o) begin
      valid_d = 1'b0;
    end else if (rd_active_i && !valid_q) begin
      data_d  = sel_hi_i ? {pix4_i, pix3_i} : {pix2_i, pix1_i};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/pixel_sequencer.sv
// Frame controller: erase -> expose -> convert (ramp) -> read12 -> read34,
// with single-shot/continuous frames and abort.
module pixel_sequencer
  import pixel_pkg::*;
#(
  parameter int C_ERASE   = C_ERASE_DEF,
  parameter int C_CONVERT = C_CONVERT_DEF,
  parameter int EXP_W     = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               continuous,
  input  logic               abort,
  input  logic [EXP_W-1:0]   exp_time,
  output logic               erase,
  output logic               expose,
  output logic               convert,
  output logic               read12,
  output logic               read34,
  output logic [7:0]         ramp_code,
  input  logic [PIX_W-1:0]   pixData1,
  input  logic [PIX_W-1:0]   pixData2,
  input  logic [PIX_W-1:0]   pixData3,
  input  logic [PIX_W-1:0]   pixData4,
  output logic [2*PIX_W-1:0] out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy,
  output logic               frame_done
);

  localparam int CLOG_E = $clog2(C_ERASE);
  localparam int CNT_W0 = (EXP_W > 8) ? EXP_W : 8;
  localparam int CNT_W  = (CNT_W0 > CLOG_E) ? CNT_W0 : CLOG_E;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [EXP_W-1:0]   exp_q, exp_d;
  logic               done_q, done_d;
  logic               abort_act;
  logic               accept;

  assign abort_act = abort & (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    cnt_d   = '0;
    exp_d   = exp_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ERASE;
          exp_d   = exp_time;
        end
      end
      ERASE: begin
        if (cnt_q == CNT_W'(C_ERASE - 1)) begin
          state_d = (exp_q == '0) ? CONVERT : EXPOSE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      EXPOSE: begin
        if (cnt_q == CNT_W'(exp_q - EXP_W'(1))) begin
          state_d = CONVERT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      CONVERT: begin
        if (cnt_q == CNT_W'(C_CONVERT)) begin
          state_d = READ12;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      READ12: begin
        if (accept) state_d = READ34;
      end
      READ34: begin
        if (accept) begin
          done_d = 1'b1;
          if (continuous) begin
            state_d = ERASE;
            exp_d   = exp_time;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (abort_act) begin
      state_d = IDLE;
      cnt_d   = '0;
      exp_d   = exp_q;
      done_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      exp_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      exp_q   <= exp_d;
      done_q  <= done_d;
    end
  end

  pixel_read_capture u_capture (
    .clk_i       (clk),
    .rst_ni      (reset),
    .rd_active_i ((state_q == READ12) || (state_q == READ34)),
    .sel_hi_i    (state_q == READ34),
    .clear_i     (abort_act),
    .pix1_i      (pixData1),
    .pix2_i      (pixData2),
    .pix3_i      (pixData3),
    .pix4_i      (pixData4),
    .ready_i     (out_ready),
    .data_o      (out_data),
    .valid_o     (out_valid),
    .accept_o    (accept)
  );

  // Every output is a decode of registered state only.
  assign erase      = (state_q == ERASE);
  assign expose     = (state_q == EXPOSE);
  assign convert    = (state_q == CONVERT);
  assign read12     = (state_q == READ12);
  assign read34     = (state_q == READ34);
  assign ramp_code  = convert ? cnt_q[7:0] : 8'd0;
  assign out_last   = out_valid & read34;
  assign busy       = (state_q != IDLE);
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_sequencer.sv
// Directed self-checking bench for pixel_sequencer.
module tb_pixel_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, continuous, abort, out_ready;
  logic [7:0]  exp_time;
  logic [7:0]  pix1, pix2, pix3, pix4;
  logic        erase, expose, convert, read12, read34;
  logic [7:0]  ramp_code;
  logic [15:0] out_data;
  logic        out_valid, out_last, busy, frame_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_sequencer #(.C_ERASE(5), .C_CONVERT(255), .EXP_W(8)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .abort(abort), .exp_time(exp_time),
    .erase(erase), .expose(expose), .convert(convert),
    .read12(read12), .read34(read34), .ramp_code(ramp_code),
    .pixData1(pix1), .pixData2(pix2), .pixData3(pix3), .pixData4(pix4),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .busy(busy), .frame_done(frame_done)
  );

  wire [4:0] ctrl = {erase, expose, convert, read12, read34};

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic start_frame(input logic [7:0] e);
    exp_time = e;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0; start = 0; continuous = 0; abort = 0; out_ready = 0;
    exp_time = 0; pix1 = 8'h11; pix2 = 8'h22; pix3 = 8'h33; pix4 = 8'h44;
    tick(); tick();
    checks++;
    if ({ctrl, out_valid, out_last, busy, frame_done} !== 9'b0 || ramp_code !== 8'd0 || out_data !== 16'd0) begin
      errors++;
      $display("FAIL reset_state ctrl=%b v=%b busy=%b fd=%b ramp=%h data=%h required all zero",
               ctrl, out_valid, busy, frame_done, ramp_code, out_data);
    end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_full_frame;
    out_ready = 1; continuous = 0;
    start_frame(8'd10);
    exp_time = 8'd3;  // must not affect the running frame
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ctrl !== 5'b10000) begin errors++; $display("FAIL erase_phase cyc=%0d ctrl=%b required 10000", i, ctrl); end
      tick();
    end
    for (int i = 0; i < 10; i++) begin
      checks++;
      if (ctrl !== 5'b01000) begin errors++; $display("FAIL expose_phase cyc=%0d ctrl=%b required 01000", i, ctrl); end
      tick();
    end
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (ctrl !== 5'b00100 || ramp_code !== i[7:0]) begin
        errors++; $display("FAIL convert_ramp cyc=%0d ctrl=%b ramp=%0d required 00100/%0d", i, ctrl, ramp_code, i);
      end
      tick();
    end
    checks++;
    if (ctrl !== 5'b00010 || out_valid !== 1'b0 || ramp_code !== 8'd0) begin
      errors++; $display("FAIL read12_settle ctrl=%b v=%b ramp=%0d required 00010/0/0", ctrl, out_valid, ramp_code);
    end
    tick();
    checks++;
    if (ctrl !== 5'b00010 || out_valid !== 1'b1 || out_data !== 16'h2211 || out_last !== 1'b0) begin
      errors++; $display("FAIL beat12 ctrl=%b v=%b data=%h last=%b required 00010/1/2211/0", ctrl, out_valid, out_data, out_last);
    end
    tick();
    checks++;
    if (ctrl !== 5'b00001 || out_valid !== 1'b0) begin
      errors++; $display("FAIL read34_settle ctrl=%b v=%b required 00001/0", ctrl, out_valid);
    end
    tick();
    checks++;
    if (ctrl !== 5'b00001 || out_valid !== 1'b1 || out_data !== 16'h4433 || out_last !== 1'b1 || frame_done !== 1'b0) begin
      errors++; $display("FAIL beat34 ctrl=%b v=%b data=%h last=%b fd=%b required 00001/1/4433/1/0",
                         ctrl, out_valid, out_data, out_last, frame_done);
    end
    tick();
    checks++;
    if (ctrl !== 5'b0 || busy !== 1'b0 || frame_done !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL frame_end ctrl=%b busy=%b fd=%b v=%b required 0/0/1/0", ctrl, busy, frame_done, out_valid);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL done_pulse fd=%b busy=%b required 0/0", frame_done, busy);
    end
  endtask

  task automatic test_exp_zero;
    logic saw_expose, got_done;
    out_ready = 1; continuous = 0;
    start_frame(8'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (ctrl !== 5'b10000) begin errors++; $display("FAIL exp0_erase cyc=%0d ctrl=%b required 10000", i, ctrl); end
      tick();
    end
    checks++;
    if (ctrl !== 5'b00100 || ramp_code !== 8'd0) begin
      errors++; $display("FAIL exp0_convert ctrl=%b ramp=%0d required 00100/0", ctrl, ramp_code);
    end
    saw_expose = 0; got_done = 0;
    for (int i = 0; i < 400 && !got_done; i++) begin
      tick();
      if (expose) saw_expose = 1;
      if (frame_done) got_done = 1;
    end
    checks++;
    if (saw_expose !== 1'b0 || got_done !== 1'b1) begin
      errors++; $display("FAIL exp0_complete saw_expose=%b done=%b required 0/1", saw_expose, got_done);
    end
    tick();
  endtask

  task automatic test_backpressure;
    out_ready = 0; continuous = 0;
    start_frame(8'd2);
    for (int i = 0; i < 300 && !read12; i++) tick();
    checks++;
    if (read12 !== 1'b1 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_reach_read12 read12=%b v=%b required 1/0", read12, out_valid);
    end
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (read12 !== 1'b1 || out_valid !== 1'b1 || out_data !== 16'h2211) begin
        errors++; $display("FAIL bp_hold cyc=%0d read12=%b v=%b data=%h required 1/1/2211", i, read12, out_valid, out_data);
      end
      if (i == 5) pix1 = 8'h55;
      tick();
    end
    pix1 = 8'h11;
    out_ready = 1;
    tick();
    checks++;
    if (ctrl !== 5'b00001 || out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_release ctrl=%b v=%b required 00001/0", ctrl, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 16'h4433 || out_last !== 1'b1) begin
      errors++; $display("FAIL bp_beat34 v=%b data=%h last=%b required 1/4433/1", out_valid, out_data, out_last);
    end
    tick();
    checks++;
    if (frame_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL bp_done fd=%b busy=%b required 1/0", frame_done, busy);
    end
    tick();
  endtask

  task automatic test_continuous;
    logic got_done;
    out_ready = 1; continuous = 1;
    start_frame(8'd3);
    for (int i = 0; i < 300 && !(read34 && out_valid); i++) tick();
    checks++;
    if (read34 !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL cont_reach_beat34 read34=%b v=%b required 1/1", read34, out_valid);
    end
    exp_time = 8'd1;
    tick();
    continuous = 0;
    checks++;
    if (frame_done !== 1'b1 || ctrl !== 5'b10000 || busy !== 1'b1) begin
      errors++; $display("FAIL cont_restart fd=%b ctrl=%b busy=%b required 1/10000/1", frame_done, ctrl, busy);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (ctrl !== 5'b10000) begin errors++; $display("FAIL cont_erase cyc=%0d ctrl=%b required 10000", i, ctrl); end
      tick();
    end
    checks++;
    if (ctrl !== 5'b01000) begin errors++; $display("FAIL cont_expose ctrl=%b required 01000", ctrl); end
    tick();
    checks++;
    if (ctrl !== 5'b00100) begin errors++; $display("FAIL cont_convert ctrl=%b required 00100", ctrl); end
    got_done = 0;
    for (int i = 0; i < 300 && !got_done; i++) begin
      tick();
      if (frame_done) got_done = 1;
    end
    checks++;
    if (got_done !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL cont_second_frame done=%b busy=%b required 1/0", got_done, busy);
    end
    tick();
  endtask

  task automatic test_abort;
    out_ready = 1; continuous = 0;
    start_frame(8'd10);
    for (int i = 0; i < 8; i++) tick();
    checks++;
    if (expose !== 1'b1) begin errors++; $display("FAIL abort_setup expose=%b required 1", expose); end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (ctrl !== 5'b0 || busy !== 1'b0 || out_valid !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL abort_expose ctrl=%b busy=%b v=%b fd=%b required all 0", ctrl, busy, out_valid, frame_done);
    end
    abort = 1;
    tick();
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy=%b required 0", busy); end
    start = 1; exp_time = 8'd0;
    tick();
    start = 0; abort = 0;
    checks++;
    if (ctrl !== 5'b10000) begin errors++; $display("FAIL abort_start_win ctrl=%b required 10000", ctrl); end
    abort = 1;
    tick();
    abort = 0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_erase busy=%b required 0", busy); end
    out_ready = 0;
    start_frame(8'd0);
    for (int i = 0; i < 300 && !(read12 && out_valid); i++) tick();
    out_ready = 1;
    tick();
    out_ready = 0;
    tick();
    checks++;
    if (read34 !== 1'b1 || out_valid !== 1'b1) begin
      errors++; $display("FAIL abort_r34_setup read34=%b v=%b required 1/1", read34, out_valid);
    end
    abort = 1; out_ready = 1;
    tick();
    abort = 0; out_ready = 0;
    checks++;
    if (ctrl !== 5'b0 || busy !== 1'b0 || out_valid !== 1'b0 || out_last !== 1'b0 || frame_done !== 1'b0) begin
      errors++; $display("FAIL abort_read34 ctrl=%b busy=%b v=%b last=%b fd=%b required all 0",
                         ctrl, busy, out_valid, out_last, frame_done);
    end
    tick();
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL abort_no_done fd=%b required 0", frame_done); end
  endtask

  task automatic test_reset_mid_convert;
    logic bad;
    out_ready = 1; continuous = 0;
    start_frame(8'd0);
    for (int i = 0; i < 40 && !convert; i++) tick();
    for (int i = 0; i < 10; i++) tick();
    checks++;
    if (convert !== 1'b1) begin errors++; $display("FAIL rst_setup convert=%b required 1", convert); end
    reset = 0;
    #2;
    checks++;
    if (ctrl !== 5'b0 || busy !== 1'b0 || ramp_code !== 8'd0) begin
      errors++; $display("FAIL rst_async ctrl=%b busy=%b ramp=%0d required 0/0/0", ctrl, busy, ramp_code);
    end
    tick();
    reset = 1;
    tick();
    checks++;
    if ({ctrl, out_valid, out_last, busy, frame_done} !== 9'b0 || ramp_code !== 8'd0 || out_data !== 16'd0) begin
      errors++; $display("FAIL rst_release ctrl=%b v=%b busy=%b fd=%b data=%h required all zero",
                         ctrl, out_valid, busy, frame_done, out_data);
    end
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (frame_done || busy) bad = 1;
    end
    checks++;
    if (bad !== 1'b0) begin errors++; $display("FAIL rst_stay_idle bad=%b required 0", bad); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog timeout");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_full_frame();
    test_exp_zero();
    test_backpressure();
    test_continuous();
    test_abort();
    test_reset_mid_convert();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_sequencer.md
Name: pixel_sequencer

Overview:
- Frame-level controller for the 2x2 pixel block.
- Sequences erase -> expose -> convert -> read12 -> read34 with a programmable exposure time.
- Drives the digital ADC ramp code during conversion.
- Captures pixel bus data during the read phases and hands it downstream over a ready/valid interface, one 16-bit beat per pixel pair.
- Supports single-shot and continuous frames, plus an abort.

Parameters:
- C_ERASE, 5: erase phase length in clock cycles (>=1).
- C_CONVERT, 255: last ramp code; convert phase lasts C_CONVERT+1 cycles.
- EXP_W, 8: width of the exposure-time input.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  level; sampled in IDLE to begin a frame.
- continuous  input  1  when high at end of READ34, the next frame starts without returning to IDLE.
- abort  input  1  synchronous; ends the frame.
- exp_time  input  EXP_W  exposure length in cycles; latched on start.
- erase, expose, convert, read12, read34  output  1 each  pixel phase controls, one-hot or all zero.
- ramp_code  output  8  digital ramp to pixel comparators; valid while convert=1.
- pixData1..pixData4  input  8 each  pixel output buses; driven by pixels during read12 (1,2) and read34 (3,4).
- out_data  output  16  captured pair: {pixData2,pixData1} or {pixData4,pixData3}.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accept.
- out_last  output  1  high with the READ34 beat.
- busy  output  1  high in any state except IDLE.
- frame_done  output  1  one-cycle pulse when the READ34 beat is accepted.

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, phase counter=0, all outputs 0, latched exposure=0. Reset mid-frame abandons the frame; no frame_done.
- All outputs are registered and decoded from the state register: no combinational path from inputs to outputs except none.
- IDLE: controls 0, busy=0.
  - start=1 at edge k -> latch exp_time; ERASE from cycle k+1 (erase=1 first visible cycle k+1).
- ERASE: erase=1 for exactly C_ERASE cycles.
  - Then EXPOSE; if latched exposure=0, skip directly to CONVERT.
- EXPOSE: expose=1 for exactly latched-exposure cycles, then CONVERT.
- CONVERT: convert=1 for C_CONVERT+1 cycles.
  - ramp_code=0 in the first cycle, +1 per cycle, reaching C_CONVERT in the last cycle.
  - No wrap; ramp_code returns to 0 outside CONVERT.
- READ12: read12=1.
  - Cycle 1 is bus settle: out_valid=0.
  - At the end of cycle 1, capture {pixData2,pixData1} into out_data.
  - From cycle 2, out_valid=1; out_data is held stable until out_ready=1 at a rising edge. Then READ34 next cycle, out_valid=0.
- READ34: identical settle/capture/hold with {pixData4,pixData3}; out_last=1 while out_valid=1.
  - On accept: frame_done=1 for one cycle.
  - Next state is ERASE if continuous=1 at that edge, else IDLE.
  - Continuous frames re-latch exp_time at that same edge.
- Minimum read phase is 2 cycles per beat with out_ready tied high.
  - Backpressure stalls indefinitely; pixel controls stay asserted throughout the stall.
- abort=1 at any edge outside IDLE: IDLE next cycle, all controls and out_valid cleared, no frame_done.
  - abort has priority over a simultaneous out_ready.
  - abort in IDLE is ignored.
  - abort and start together in IDLE: start wins.
- start while busy is ignored; exp_time changes mid-frame have no effect.
- Phase counter width is max(EXP_W, 8, clog2(C_ERASE)) bits. It is cleared on every state change, so no overflow is possible.

Decomposition:
- Package pixel_pkg:
  - state enum typedef {IDLE, ERASE, EXPOSE, CONVERT, READ12, READ34} with 3-bit encoding.
  - Default constants C_ERASE_DEF=5 and C_CONVERT_DEF=255.
  - Pixel data width constant PIX_W=8.
- One sub-module, pixel_read_capture:
  - 16-bit capture register, settle-cycle flag and ready/valid hold logic.
  - Instantiated once and controlled by the state machine.

Test Plan:
- reset low mid-CONVERT -> on deassert all outputs 0, state IDLE, no frame_done.
- exp_time=10, start pulse, out_ready=1, continuous=0:
  - erase high 5 cycles, expose 10, convert 256 with ramp_code 0..255.
  - Two beats: 0x2211, then 0x4433 with out_last (pixData1..4 = 0x11, 0x22, 0x33, 0x44).
  - frame_done pulses once, then IDLE.
- exp_time=0 -> expose never asserted; convert starts the cycle after the 5th erase cycle.
- out_ready=0 for 20 cycles in READ12 -> out_valid stays high, out_data=0x2211 stable, read12 stays high; after out_ready=1, read34 asserts next cycle.
- continuous=1 -> after the READ34 accept, erase asserts the next cycle with no IDLE cycle; a new exp_time is applied.
- abort in EXPOSE, and separately together with out_ready in READ34 -> IDLE next cycle, outputs 0, no frame_done.
